// File: rtl/cfg_reg_pkg.sv
// ---------------------------------------------------------------------------
// cfg_reg_pkg
// Shared types and helpers for the cfg_reg_bank register block.
//   cfg_reg_attr_e : per-register attribute (read-write, read-only, pulse)
//   AUTOINC_BIT    : address-word bit selecting auto-increment (default width)
//   autoinc_bit()  : same position for an arbitrary data width
//   attr_of()      : decodes the RO/PULSE masks into an attribute
// Optional feature macro used by the bank: CFG_REG_BANK_SHADOW_EN.
// ---------------------------------------------------------------------------
package cfg_reg_pkg;

    typedef enum logic [1:0] {
        RW    = 2'd0,
        RO    = 2'd1,
        PULSE = 2'd2
    } cfg_reg_attr_e;

    localparam int DEFAULT_DATA_W = 32;
    localparam int AUTOINC_BIT    = DEFAULT_DATA_W - 1;

    function automatic int autoinc_bit(input int data_w);
        return data_w - 1;
    endfunction

    // Read-only takes priority: a register cannot be written, so it cannot pulse.
    function automatic cfg_reg_attr_e attr_of(input int i,
                                              input logic [255:0] ro_mask,
                                              input logic [255:0] pulse_mask);
        if (ro_mask[i])
            return RO;
        else if (pulse_mask[i])
            return PULSE;
        else
            return RW;
    endfunction

endpackage

// File: rtl/cfg_reg_cell.sv
// ---------------------------------------------------------------------------
// cfg_reg_cell
// One register of the bank, including self-clearing and shadow/commit logic.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   i_wr       : qualified write enable (address match, address legal)
//   i_wdata    : write data
//   i_commit   : shadow commit strobe (only used with CFG_REG_BANK_SHADOW_EN)
//   o_q        : register value driven to the fabric
//   o_rd       : value returned on a read
//   o_stb      : one-cycle strobe when o_q takes a newly written value
// Macro: CFG_REG_BANK_SHADOW_EN selects the shadow-bank variant.
// ---------------------------------------------------------------------------
module cfg_reg_cell
    import cfg_reg_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter cfg_reg_attr_e     ATTR      = RW,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_commit,
    output logic [DATA_W-1:0] o_q,
    output logic [DATA_W-1:0] o_rd,
    output logic              o_stb
);

    localparam bit IS_PULSE = (ATTR == PULSE);

    // Read-only cells keep their reset value forever; the fabric never sees writes.
    logic w_wr;
    assign w_wr = i_wr && (ATTR != RO);

    logic [DATA_W-1:0] r_q;
    logic              r_stb;

`ifdef CFG_REG_BANK_SHADOW_EN
    logic [DATA_W-1:0] r_shadow;
    logic              r_dirty;
    logic [DATA_W-1:0] w_shadow_next;
    logic              w_fire;

    // A write in the commit cycle is folded into that commit.
    assign w_shadow_next = w_wr ? i_wdata : r_shadow;
    assign w_fire        = i_commit && (r_dirty || w_wr);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q      <= RESET_VAL;
            r_shadow <= RESET_VAL;
            r_dirty  <= 1'b0;
            r_stb    <= 1'b0;
        end else begin
            r_stb <= w_fire;
            if (i_commit) begin
                r_dirty  <= 1'b0;
                // A pulse register's shadow is consumed by the commit.
                r_shadow <= IS_PULSE ? RESET_VAL : w_shadow_next;
            end else begin
                r_dirty  <= r_dirty | w_wr;
                r_shadow <= w_shadow_next;
            end
            if (w_fire)
                r_q <= w_shadow_next;
            else if (IS_PULSE)
                r_q <= RESET_VAL;
        end
    end

    assign o_rd = r_shadow;
`else
    logic w_unused_commit;
    assign w_unused_commit = i_commit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q   <= RESET_VAL;
            r_stb <= 1'b0;
        end else begin
            r_stb <= w_wr;
            // A write in the clearing cycle wins and restarts the one-cycle hold.
            if (w_wr)
                r_q <= i_wdata;
            else if (IS_PULSE)
                r_q <= RESET_VAL;
        end
    end

    assign o_rd = r_q;
`endif

    assign o_q   = r_q;
    assign o_stb = r_stb;

endmodule

// File: rtl/cfg_reg_bank.sv
// ---------------------------------------------------------------------------
// cfg_reg_bank
// Parametrised register bank addressed by the Master FPGA.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   rx_data         : address word (on reg_num_le) or write data (on wr_en)
//   reg_num_le      : latch rx_data as the address word
//   wr_en / rd_en   : write / read the current address
//   tx_data         : registered read data, valid while rd_valid is high
//   rd_valid        : one-cycle read-data-valid pulse
//   illegal_reg_num : current address word is illegal
//   ro_data         : live values returned by read-only registers
//   reg_q           : register contents driven to the fabric
//   wr_stb          : one-cycle write strobe per register
//   commit          : shadow commit strobe
// Macro: CFG_REG_BANK_SHADOW_EN enables the shadow bank with commit.
// Address word: bit DATA_W-1 = auto-increment, bits ADDR_W-1:0 = register.
// ---------------------------------------------------------------------------
module cfg_reg_bank
    import cfg_reg_pkg::*;
#(
    parameter int                         DATA_W     = 32,
    parameter int                         NUM_REGS   = 32,
    parameter logic [NUM_REGS-1:0]        RO_MASK    = {NUM_REGS{1'b0}},
    parameter logic [NUM_REGS-1:0]        PULSE_MASK = {NUM_REGS{1'b0}},
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS = {NUM_REGS*DATA_W{1'b0}}
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            rx_data,
    input  logic                         reg_num_le,
    input  logic                         wr_en,
    input  logic                         rd_en,
    output logic [DATA_W-1:0]            tx_data,
    output logic                         rd_valid,
    output logic                         illegal_reg_num,
    input  logic [NUM_REGS*DATA_W-1:0]   ro_data,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          wr_stb,
    input  logic                         commit
);

    localparam int ADDR_W   = $clog2(NUM_REGS);
    localparam int AUTOINC  = autoinc_bit(DATA_W);
    localparam int ADDR_SPAN = 2 ** ADDR_W;
    // Bits between the register field and the auto-increment flag must be 0.
    localparam logic [DATA_W-1:0] HI_MASK =
        ({DATA_W{1'b1}} << ADDR_W) & ~({{(DATA_W-1){1'b0}}, 1'b1} << AUTOINC);
    localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

    logic [ADDR_W-1:0] r_addr;
    logic              r_autoinc;
    logic              r_illegal;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_tx;

    logic [ADDR_W-1:0] w_addr_inc;
    logic              w_le_illegal;
    logic              w_access;
    logic [DATA_W-1:0] w_rd_sel;
    logic [DATA_W-1:0] w_rd_vals [ADDR_SPAN];

    assign w_access     = wr_en || rd_en;
    assign w_addr_inc   = (r_addr == LAST_ADDR) ? '0 : r_addr + ADDR_W'(1);
    assign w_le_illegal = (|(rx_data & HI_MASK)) ||
                          ({1'b0, rx_data[ADDR_W-1:0]} >= NUM_REGS_W);
    assign w_rd_sel     = w_rd_vals[r_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr     <= '0;
            r_autoinc  <= 1'b0;
            r_illegal  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_tx       <= '0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en)
                r_tx <= r_illegal ? '0 : w_rd_sel;
            // A new address word overrides any increment from a same-cycle access.
            if (reg_num_le) begin
                r_addr    <= rx_data[ADDR_W-1:0];
                r_autoinc <= rx_data[AUTOINC];
                r_illegal <= w_le_illegal;
            end else if (r_autoinc && w_access) begin
                r_addr    <= w_addr_inc;
                r_illegal <= ({1'b0, w_addr_inc} >= NUM_REGS_W);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ADDR_SPAN; gi++) begin : g_reg
            if (gi < NUM_REGS) begin : g_cell
                localparam cfg_reg_attr_e ATTR =
                    attr_of(gi, 256'(RO_MASK), 256'(PULSE_MASK));
                logic              w_wr;
                logic [DATA_W-1:0] w_cell_rd;

                assign w_wr = wr_en && !r_illegal && (r_addr == ADDR_W'(gi));

                cfg_reg_cell #(
                    .DATA_W    (DATA_W),
                    .ATTR      (ATTR),
                    .RESET_VAL (RESET_VALS[gi*DATA_W +: DATA_W])
                ) u_cell (
                    .clk      (clk),
                    .reset    (reset),
                    .i_wr     (w_wr),
                    .i_wdata  (rx_data),
                    .i_commit (commit),
                    .o_q      (reg_q[gi*DATA_W +: DATA_W]),
                    .o_rd     (w_cell_rd),
                    .o_stb    (wr_stb[gi])
                );

                assign w_rd_vals[gi] = (ATTR == RO) ? ro_data[gi*DATA_W +: DATA_W]
                                                    : w_cell_rd;
            end else begin : g_pad
                // Unused encodings are always illegal; the read path masks them.
                assign w_rd_vals[gi] = '0;
            end
        end
    endgenerate

    assign tx_data         = r_tx;
    assign rd_valid        = r_rd_valid;
    assign illegal_reg_num = r_illegal;

endmodule

// File: tb/tb_cfg_reg_bank.sv
module tb_cfg_reg_bank;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam logic [NR-1:0]    RO_M    = 32'h0000_0080;
    localparam logic [NR-1:0]    PULSE_M = 32'h0000_0008;
    localparam logic [NR*DW-1:0] RV =
        ((NR*DW)'(32'h77)     << (7*DW)) |
        ((NR*DW)'(32'h33)     << (3*DW)) |
        ((NR*DW)'(32'd70000)  << (2*DW)) |
        ((NR*DW)'(32'hA0));
`ifdef CFG_REG_BANK_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DW-1:0]     rx_data = '0;
    logic              reg_num_le = 1'b0;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic              commit = 1'b0;
    logic [DW-1:0]     tx_data;
    logic              rd_valid;
    logic              illegal_reg_num;
    logic [NR*DW-1:0]  ro_data = '0;
    logic [NR*DW-1:0]  reg_q;
    logic [NR-1:0]     wr_stb;

    always #5 clk = ~clk;

    cfg_reg_bank #(
        .DATA_W     (DW),
        .NUM_REGS   (NR),
        .RO_MASK    (RO_M),
        .PULSE_MASK (PULSE_M),
        .RESET_VALS (RV)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_data         (rx_data),
        .reg_num_le      (reg_num_le),
        .wr_en           (wr_en),
        .rd_en           (rd_en),
        .tx_data         (tx_data),
        .rd_valid        (rd_valid),
        .illegal_reg_num (illegal_reg_num),
        .ro_data         (ro_data),
        .reg_q           (reg_q),
        .wr_stb          (wr_stb),
        .commit          (commit)
    );

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] m_reg [NR];
    int m_stb [NR];
    int seen_stb [NR];
    int m_addr = 0;
    bit m_auto = 1'b0;
    bit m_ill = 1'b0;
    int n_reads = 0;
    int n_valid = 0;

    task automatic check(input string tag, input logic [NR*DW-1:0] obs,
                         input logic [NR*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every rd_valid pops one expected read value.
    always @(negedge clk) begin
        for (int i = 0; i < NR; i++)
            if (wr_stb[i] === 1'b1) seen_stb[i]++;
        if (rd_valid === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0)
                check("rd_valid_unexpected", 1, 0);
            else
                check("tx_data", tx_data, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rv(input int i);
        return RV[i*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] qslice(input int i);
        return reg_q[i*DW +: DW];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NR; i++) m_reg[i] = rv(i);
        m_addr = 0; m_auto = 1'b0; m_ill = 1'b0;
    endtask

    task automatic m_advance();
        if (m_auto) begin
            m_addr = (m_addr == NR-1) ? 0 : m_addr + 1;
            m_ill  = 1'b0;
        end
    endtask

    function automatic logic [DW-1:0] m_read_val();
        if (m_ill) return '0;
        if (RO_M[m_addr]) return ro_data[m_addr*DW +: DW];
        return m_reg[m_addr];
    endfunction

    task automatic latch(input logic [DW-1:0] v);
        rx_data = v; reg_num_le = 1'b1;
        tick();
        reg_num_le = 1'b0;
        m_addr = int'(v[4:0]); m_auto = v[31]; m_ill = (v[30:5] != 0);
    endtask

    // Pulse registers are only ever read long after they cleared, so the
    // model keeps their reset value as the readable content.
    task automatic do_write(input logic [DW-1:0] v, input bit cm);
        rx_data = v; wr_en = 1'b1; commit = cm;
        tick();
        wr_en = 1'b0; commit = 1'b0;
        if (!m_ill && !RO_M[m_addr]) begin
            if (cm || !SHADOW) m_stb[m_addr]++;
            if (!PULSE_M[m_addr]) m_reg[m_addr] = v;
        end
        m_advance();
    endtask

    task automatic do_read();
        exp_q.push_back(m_read_val());
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_reads++;
        check("rd_valid_latency", rd_valid, 1);
        m_advance();
    endtask

    logic [NR*DW-1:0] snap;

    initial begin
        for (int i = 0; i < NR; i++) begin m_stb[i] = 0; seen_stb[i] = 0; end
        m_reset();
        ro_data[7*DW +: DW] = 32'h1234_5678;

        // Reset state
        tick(); tick();
        check("rst_reg_q", reg_q, RV);
        check("rst_wr_stb", wr_stb, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_illegal", illegal_reg_num, 0);
        reset = 1'b0;

        // 1: read all reset values
        latch(32'h8000_0000);
        for (int i = 0; i < NR; i++) do_read();

        // 2: burst write then burst read, with wrap
        latch(32'h8000_0000);
        for (int i = 0; i < NR; i++) do_write(32'h100 + i, 1'b1);
        check("burst_q1", qslice(1), 32'h101);
        check("burst_q31", qslice(31), 32'h11F);
        latch(32'h8000_0000);
        for (int i = 0; i < NR; i++) do_read();
        do_read();  // wrapped back to register 0

        // 3: illegal address
        latch(32'h0000_0040);
        check("illegal_set", illegal_reg_num, 1);
        snap = reg_q;
        do_write(32'hDEAD, 1'b1);
        check("illegal_no_stb", wr_stb, 0);
        check("illegal_no_change", reg_q, snap);
        do_read();
        latch(32'h0000_001F);
        check("illegal_clear", illegal_reg_num, 0);

        // 4: read-only register
        latch(32'h0000_0007);
        do_write(32'h0, 1'b1);
        check("ro_q_unchanged", qslice(7), 32'h77);
        check("ro_no_stb", wr_stb, 0);
        do_read();
        ro_data[7*DW +: DW] = 32'hCAFE_F00D;
        do_read();

        // 5: pulse register
        latch(32'h0000_0003);
        do_write(32'h1, 1'b1);
        check("pulse_q_set", qslice(3), 32'h1);
        check("pulse_stb", wr_stb, 32'h8);
        tick();
        check("pulse_q_clear", qslice(3), 32'h33);
        check("pulse_stb_clear", wr_stb, 0);
        do_write(32'h1, 1'b1);
        do_write(32'h2, 1'b1);
        check("pulse_rewrite", qslice(3), 32'h2);
        tick();
        check("pulse_rewrite_clear", qslice(3), 32'h33);

        // Simultaneous write and read: read returns pre-write value
        latch(32'h0000_0004);
        do_write(32'hAAAA, 1'b1);
        exp_q.push_back(32'hAAAA);
        rx_data = 32'hBBBB; wr_en = 1'b1; rd_en = 1'b1; commit = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0; commit = 1'b0;
        n_reads++; m_reg[4] = 32'hBBBB; m_stb[4]++;
        check("rdwr_valid", rd_valid, 1);
        do_read();

        // Address latch with read: read uses old address, no increment after
        latch(32'h8000_0004);
        exp_q.push_back(m_reg[4]);
        rx_data = 32'h8000_0009; reg_num_le = 1'b1; rd_en = 1'b1;
        tick();
        reg_num_le = 1'b0; rd_en = 1'b0;
        n_reads++; m_addr = 9; m_auto = 1'b1; m_ill = 1'b0;
        do_read();
        do_read();

        // 6: shadow / commit behaviour
        latch(32'h0000_0005);
        do_write(32'hA5, 1'b0);
        if (SHADOW) begin
            check("shadow_q_hold", qslice(5), 32'h105);
            check("shadow_no_stb", wr_stb, 0);
            do_read();
            commit = 1'b1;
            tick();
            commit = 1'b0;
            m_stb[5]++;
            check("shadow_commit_q", qslice(5), 32'hA5);
            check("shadow_commit_stb", wr_stb, 32'h20);
        end else begin
            check("direct_q", qslice(5), 32'hA5);
            check("direct_stb", wr_stb, 32'h20);
            commit = 1'b1;
            tick();
            commit = 1'b0;
            check("commit_ignored", wr_stb, 0);
        end

        // Reset mid-burst drops the in-flight read
        latch(32'h8000_0000);
        do_read();
        do_read();
        rd_en = 1'b1; reset = 1'b1;
        tick();
        rd_en = 1'b0; reset = 1'b0;
        m_reset();
        check("midrst_rd_valid", rd_valid, 0);
        check("midrst_tx_data", tx_data, 0);
        check("midrst_illegal", illegal_reg_num, 0);
        check("midrst_reg_q", reg_q, RV);
        check("midrst_wr_stb", wr_stb, 0);
        do_read();
        do_read();

        tick(); tick();
        check("scoreboard_empty", exp_q.size(), 0);
        check("rd_valid_count", n_valid, n_reads);
        for (int i = 0; i < NR; i++) check("wr_stb_count", seen_stb[i], m_stb[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cfg_reg_bank.md
Name: cfg_reg_bank

Overview:
- Parametrised successor to the fixed 32x32 slave-FPGA register block.
- Provides a register bank addressed by the Master FPGA, with NUM_REGS registers of DATA_W bits each.
- Each register's attributes come from parameter masks: read-only, self-clearing pulse, reset value.
- Adds address auto-increment for burst access, a registered read with a valid flag, and per-register write strobes to the acquisition logic.

Parameters:
- DATA_W, 32: register width; also the width of rx_data and tx_data.
- NUM_REGS, 32: number of registers; allowed range 2..256.
- ADDR_W, $clog2(NUM_REGS): width of the internal address pointer; derived, never overridden.
- RO_MASK, all zeros ({NUM_REGS{1'b0}}): bit i=1 makes register i read-only; reads return ro_data slice i.
- PULSE_MASK, all zeros ({NUM_REGS{1'b0}}): bit i=1 makes register i self-clearing.
- RESET_VALS, all zeros ({NUM_REGS*DATA_W{1'b0}}): flat vector; slice i is the reset value of register i.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- rx_data  in  DATA_W  address or write data from the Master FPGA.
- reg_num_le  in  1  latch rx_data as the address word.
- wr_en  in  1  write rx_data to the current address.
- rd_en  in  1  read the current address.
- tx_data  out  DATA_W  read data.
- rd_valid  out  1  one-cycle pulse; tx_data is valid while it is high.
- illegal_reg_num  out  1  the current address word is illegal.
- ro_data  in  NUM_REGS*DATA_W  live values for the read-only registers.
- reg_q  out  NUM_REGS*DATA_W  register contents driven to the fabric.
- wr_stb  out  NUM_REGS  one-cycle write strobe per register.
- commit  in  1  shadow commit strobe; used only with CFG_REG_BANK_SHADOW_EN.

Behaviour:
- Reset values: addr=0, autoinc=0, illegal_reg_num=0, tx_data=0, rd_valid=0, wr_stb=0, reg_q=RESET_VALS.
- Address word, latched on reg_num_le:
  - addr <= rx_data[ADDR_W-1:0]; autoinc <= rx_data[DATA_W-1].
  - illegal <= (rx_data[DATA_W-2:ADDR_W] != 0) or (rx_data[ADDR_W-1:0] >= NUM_REGS).
  - illegal_reg_num is registered, so it is visible the cycle after the latch.
- Write, on wr_en with addr legal and not RO: reg i <= rx_data. reg_q and wr_stb[i] both update on the same edge, so they are visible together the following cycle.
- Writes to RO or illegal addresses: contents unchanged, no wr_stb. Auto-increment still applies.
- PULSE_MASK register i:
  - Holds the written value for exactly one cycle, then returns to its RESET_VALS slice.
  - A write on the cycle it clears takes effect; the new value is held for one more cycle.
- Read, on rd_en: tx_data <= value at addr one cycle later, with rd_valid=1 for that cycle.
  - Read-write register: returns reg contents.
  - RO register: returns the ro_data slice, sampled on the rd_en edge.
  - Illegal address: returns 0.
  - tx_data holds its value between reads.
- Auto-increment:
  - With autoinc=1, each cycle with wr_en or rd_en advances addr by 1, once even if both are asserted.
  - NUM_REGS-1 wraps to 0.
  - After the wrap the address stays legal: illegal is cleared because addr < NUM_REGS.
- Simultaneous events:
  - reg_num_le with wr_en or rd_en: the access uses the old addr; the latched addr wins afterwards (no increment applied).
  - wr_en and rd_en on the same register: tx_data returns the pre-write value.
- reset mid-burst: everything returns to reset values on the next edge; an in-flight rd_valid is dropped.

Optional Feature:
- Macro: CFG_REG_BANK_SHADOW_EN.
- Defined:
  - Writes land in a shadow bank.
  - reg_q updates from the shadow only on the edge where commit=1.
  - wr_stb[i] fires on commit for every register written since the last commit.
  - Reads return the shadow contents.
  - A write and a commit in the same cycle: the write is included in the commit.
  - PULSE_MASK registers pulse on commit.
- Undefined: commit is ignored; writes update reg_q directly as described above.

Decomposition:
- Shared package cfg_reg_pkg:
  - cfg_reg_attr_e enumeration {RW, RO, PULSE}.
  - AUTOINC_BIT = DATA_W-1.
  - Function attr_of(i) decoding the masks.
- One sub-module: cfg_reg_cell, a single register plus its pulse/shadow logic, instantiated NUM_REGS times via generate.

Test Plan:
1. Reset, then read every register (NUM_REGS=32, RESET_VALS slice 2 = 70000) -> tx_data equals each reset value, rd_valid one cycle after each rd_en.
2. Latch address 0x80000000 (auto-increment, start at 0), then 32 back-to-back writes of 0x100+i, then latch 0x80000000 again and 32 reads -> reads return 0x100+i; addr wraps to 0; wr_stb[i] fires once each.
3. Latch address 0x00000040 -> illegal_reg_num=1 the next cycle; write 0xDEAD -> no wr_stb, no change; read -> tx_data=0 with rd_valid=1.
4. RO_MASK bit 7 set, ro_data slice 7 = 0x12345678 -> write 0 to reg 7 is ignored; read returns 0x12345678.
5. PULSE_MASK bit 3 set, write 0x1 to reg 3 -> reg_q slice 3 = 1 for exactly one cycle, then returns to its reset value; wr_stb[3] pulses once.
6. With CFG_REG_BANK_SHADOW_EN: write reg 5 = 0xA5 -> reg_q slice 5 unchanged until commit; on commit it becomes 0xA5 and wr_stb[5]=1. Separately, assert reset mid-burst -> all outputs return to reset values.
